fir_cfg_sequencer: RTL

Controller placed in front of fir_main that owns its input port and sequences coefficient configuration.
- Buffers NUM_TAPS coefficient bytes in a shadow bank.
- On commit, streams the bank into the filter with set_coeffs asserted.
- Flushes the delay line with zero samples.
- Only then passes live samples through, so the filter never mixes old and new coefficients or stale history.

---
 rtl/fir_cfg_sequencer_if.sv | 33 +++
 rtl/fir_cfg_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fir_cfg_sequencer_if.sv
// Bus between the configuration/sample source and fir_cfg_sequencer,
// plus the sequencer's drive toward fir_main and its status outputs.
interface fir_cfg_sequencer_if #(
    parameter int NUM_TAPS = 4,
    parameter int DATA_W   = 8
);
    localparam int CNT_W = $clog2(NUM_TAPS + 1);

    logic              cfg_wr;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_commit;
    logic              smp_valid;
    logic [DATA_W-1:0] smp_data;
    logic              err_clr;
    logic              smp_ready;
    logic [DATA_W-1:0] fir_x_n;
    logic              fir_tvalid;
    logic              fir_set_coeffs;
    logic              busy;
    logic              loaded;
    logic [CNT_W-1:0]  cfg_count;
    logic              err;

    modport master (
        output cfg_wr, cfg_data, cfg_commit, smp_valid, smp_data, err_clr,
        input  smp_ready, fir_x_n, fir_tvalid, fir_set_coeffs, busy, loaded, cfg_count, err
    );

    modport slave (
        input  cfg_wr, cfg_data, cfg_commit, smp_valid, smp_data, err_clr,
        output smp_ready, fir_x_n, fir_tvalid, fir_set_coeffs, busy, loaded, cfg_count, err
    );
endinterface

// File: rtl/fir_cfg_sequencer.sv
// Front-end for fir_main: buffers a shadow coefficient bank, streams it in on
// commit, flushes the delay line with zeros, then passes live samples.
module fir_cfg_sequencer #(
    parameter int NUM_TAPS = 4,
    parameter int DATA_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    fir_cfg_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_TAPS + 1);
    localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] RUN   = 2'd3;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_TAPS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TAPS - 1);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shadow_q [NUM_TAPS];
    logic [DATA_W-1:0] x_q, x_d;
    logic              tvalid_q, tvalid_d;
    logic              setc_q, setc_d;
    logic              loaded_q, loaded_d;
    logic              err_q, err_d;
    logic              open_st, commit_ok, wr_ok, new_err;

    // A commit is judged against the pre-write count; an accepted commit drops a same-cycle write.
    always_comb begin
        open_st   = (state_q == IDLE) || (state_q == RUN);
        commit_ok = bus.cfg_commit && open_st && (cnt_q == FULL);
        wr_ok     = bus.cfg_wr && open_st && (cnt_q < FULL) && !commit_ok;
        new_err   = (bus.cfg_commit && !commit_ok)
                  || (bus.cfg_wr && !wr_ok)
                  || (bus.smp_valid && (state_q != RUN));
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        if (wr_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (state_q)
            IDLE, RUN: begin
                if (commit_ok) begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                if (idx_q == LAST) begin
                    state_d = FLUSH;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            FLUSH: begin
                if (idx_q == LAST) begin
                    state_d  = RUN;
                    idx_d    = '0;
                    cnt_d    = '0;
                    loaded_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = new_err ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
    end

    // Filter drive is decoded from the state being entered, so it lines up with that state.
    always_comb begin
        setc_d   = 1'b0;
        tvalid_d = 1'b0;
        x_d      = '0;
        case (state_d)
            LOAD: begin
                setc_d = 1'b1;
                x_d    = shadow_q[idx_d];
            end
            FLUSH: tvalid_d = 1'b1;
            RUN: begin
                if ((state_q == RUN) && bus.smp_valid) begin
                    tvalid_d = 1'b1;
                    x_d      = bus.smp_data;
                end else begin
                    x_d = x_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            tvalid_q <= 1'b0;
            setc_q   <= 1'b0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            tvalid_q <= tvalid_d;
            setc_q   <= setc_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            if (wr_ok) begin
                shadow_q[cnt_q[IDX_W-1:0]] <= bus.cfg_data;
            end
        end
    end

    assign bus.smp_ready      = (state_q == RUN);
    assign bus.busy           = (state_q == LOAD) || (state_q == FLUSH);
    assign bus.fir_x_n        = x_q;
    assign bus.fir_tvalid     = tvalid_q;
    assign bus.fir_set_coeffs = setc_q;
    assign bus.loaded         = loaded_q;
    assign bus.cfg_count      = cnt_q;
    assign bus.err            = err_q;
endmodule
